cfar_window_detector: RTL and testbench
=======================================

CFAR_WINDOW_DETECTOR -- requirements
Module: cfar_window_detector

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, pixel width.
REQ-002 Parameter: WIN_COLS, default 9, window width in columns; odd, 5 to 15.
REQ-003 Parameter: GUARD, default 1, guard columns on each side of the centre; 2*GUARD+1 < WIN_COLS.
REQ-004 Parameter: ALPHA_Q, default 8'd48, threshold scale in unsigned Q4.4 (48 = 3.0).
REQ-005 Port: clk, input, 1, single clock; all logic on its rising edge.
REQ-006 Port: rst, input, 1, synchronous active-high reset.
REQ-007 Port: valid_in, input, 1, one 5x2 block beat present.
REQ-008 Port: row_in, input, 12, block start row.
REQ-009 Port: col_in, input, 12, block left column.
REQ-010 Port: pixel_in, input, 10*DATA_WIDTH, element (i,j) (row 0-4, column 0-1) at bits [(2*i+j)*DATA_WIDTH +: DATA_WIDTH].
REQ-011 Port: det_valid, output, 1, one result per qualifying beat.
REQ-012 Port: det_flag, output, 1, target detected at the cell under test (CUT).
REQ-013 Port: det_row, output, 12, row_in+2 of the CUT.
REQ-014 Port: det_col, output, 12, CUT column.
REQ-015 Port: cut_value, output, DATA_WIDTH, CUT pixel.
REQ-016 Port: ref_sum, output, DATA_WIDTH+8, sum of reference cells.

Function
REQ-017 Only column j=0 of each beat is consumed; column j=1 is ignored.
REQ-018 Stage 1 (valid_in beat): register column sum CS = sum of pixel(i,0), i=0..4, width DATA_WIDTH+3; register CUT candidate pixel(2,0), row_in and col_in.
REQ-019 Stage 2: shift CS and the candidate into WIN_COLS-deep history registers (newest at index 0); increment the fill counter, saturating at WIN_COLS.
REQ-020 Fill counter: set to 1 instead of incrementing when col_in==0 or col_in != previous col_in+1, so each row and each column discontinuity restarts the window.
REQ-021 Stage 3: ref_sum = sum of history entries excluding centre index (WIN_COLS-1)/2 +/- GUARD; N_REF = 5*(WIN_COLS-2*GUARD-1).
REQ-022 Detection: det_flag = (cut*N_REF*16 > ALPHA_Q*ref_sum), strict compare, full-width unsigned products with no truncation.
REQ-023 det_col = stage-2 col_in - (WIN_COLS-1)/2.
REQ-024 det_valid pulses exactly 3 cycles after a valid_in beat whose stage-2 fill counter equals WIN_COLS; otherwise it is 0.
REQ-025 With no valid_in, all stages hold their contents and det_valid=0; bubbles of any length do not corrupt the window.
REQ-026 Stage-3 outputs hold their last values while det_valid=0.
REQ-027 Back-to-back beats sustain one result per cycle; there is no backpressure.

Reset
REQ-028 During rst all outputs, history registers, pipeline registers and the fill counter are 0; reset takes priority over valid_in.
REQ-029 Reset mid-row discards in-flight data; the first det_valid after reset requires WIN_COLS new contiguous beats.

Configuration
REQ-030 Macro CFAR_DET_COUNT_EN defined: add output det_count (32 bits), incremented on each det_valid with det_flag=1, saturating at 2^32-1, cleared to 0 by rst and by a valid_in beat with row_in==0 and col_in==0.
REQ-031 Macro not defined: the det_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-032 Scenario: all pixels 100, row 0, col_in 0..20 contiguous -> first det_valid 3 cycles after the col_in=8 beat with det_col=4, det_row=2; then 13 results, all det_flag=0, ref_sum=3000.
REQ-033 Scenario: as REQ-032 but pixel(2,0)=1000 at col_in=10 -> det_flag=1 only for det_col=10, cut_value=1000, ref_sum=3000.
REQ-034 Scenario: 2-cycle bubbles between every beat with the REQ-033 stimulus -> identical results, each det_valid 3 cycles after its beat.
REQ-035 Scenario: col_in jumps 7 -> 12 -> fill restarts; no det_valid until the col_in=20 beat (det_col=16).
REQ-036 Scenario: rst asserted for 1 cycle at col_in=9 -> all outputs 0 the next cycle; no det_valid for the following 8 beats.
REQ-037 Scenario (CFAR_DET_COUNT_EN): 3 spikes across rows -> det_count=3; a row0/col0 beat -> det_count=0.

Source files
------------

// File: rtl/cfar_window_detector.sv
// Cell-averaging CFAR detector over a sliding window of 5-row column sums.
// Each beat contributes one column (j=0) of a 5x2 block; a result appears three
// cycles after every beat that completes a full contiguous window.
// Optional feature: define CFAR_DET_COUNT_EN to add the det_count output.
module cfar_window_detector #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned WIN_COLS   = 9,
    parameter int unsigned GUARD      = 1,
    parameter logic [7:0]  ALPHA_Q    = 8'd48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [11:0]                row_in,
    input  logic [11:0]                col_in,
    input  logic [10*DATA_WIDTH-1:0]   pixel_in,
    output logic                       det_valid,
    output logic                       det_flag,
    output logic [11:0]                det_row,
    output logic [11:0]                det_col,
    output logic [DATA_WIDTH-1:0]      cut_value,
    output logic [DATA_WIDTH+7:0]      ref_sum
`ifdef CFAR_DET_COUNT_EN
    ,
    output logic [31:0]                det_count
`endif
);

    localparam int unsigned CS_W       = DATA_WIDTH + 3;
    localparam int unsigned REF_W      = DATA_WIDTH + 8;
    localparam int unsigned PROD_W     = DATA_WIDTH + 16;
    localparam int unsigned CENTRE     = (WIN_COLS - 1) / 2;
    localparam int unsigned N_REF      = 5 * (WIN_COLS - 2 * GUARD - 1);
    localparam int          GUARD_LO   = int'(CENTRE - GUARD);
    localparam int          GUARD_HI   = int'(CENTRE + GUARD);
    localparam logic [3:0]  FILL_FULL  = 4'(WIN_COLS);
    localparam logic [11:0] CENTRE_COL = 12'(CENTRE);
    // CUT is scaled by N_REF and by 16 to match the Q4.4 threshold factor.
    localparam logic [PROD_W-1:0] CUT_SCALE = PROD_W'(N_REF * 16);

    // Stage 1 registers
    logic                  r_s1_valid;
    logic [CS_W-1:0]       r_s1_cs;
    logic [DATA_WIDTH-1:0] r_s1_cut;
    logic [11:0]           r_s1_row;
    logic [11:0]           r_s1_col;

    // Stage 2 registers (window history, newest at index 0)
    logic                  r_s2_valid;
    logic [CS_W-1:0]       r_hist_cs  [WIN_COLS];
    logic [DATA_WIDTH-1:0] r_hist_pix [WIN_COLS];
    logic [3:0]            r_fill;
    logic [11:0]           r_s2_row;
    logic [11:0]           r_s2_col;

    // Combinational nets
    logic [CS_W-1:0]       w_cs;
    logic                  w_unused;
    logic [3:0]            w_fill_next;
    logic                  w_s2_fire;
    logic [REF_W-1:0]      w_ref_sum;
    logic [DATA_WIDTH-1:0] w_cut;
    logic [PROD_W-1:0]     w_lhs;
    logic [PROD_W-1:0]     w_rhs;
    logic                  w_flag;

    // Column sum over the five rows of column 0; column 1 is deliberately dropped.
    always_comb begin
        w_cs     = '0;
        w_unused = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_cs     = w_cs + {3'b000, pixel_in[(2*i)*DATA_WIDTH +: DATA_WIDTH]};
            w_unused = w_unused ^ (^pixel_in[(2*i+1)*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Stage 1: capture column sum, CUT candidate and coordinates of a beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cs    <= '0;
            r_s1_cut   <= '0;
            r_s1_row   <= '0;
            r_s1_col   <= '0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_cs  <= w_cs;
                r_s1_cut <= pixel_in[4*DATA_WIDTH +: DATA_WIDTH];
                r_s1_row <= row_in;
                r_s1_col <= col_in;
            end
        end
    end

    // Fill count restarts on a new row (col 0) or any column gap; r_s2_col is the
    // column of the previously accepted beat.
    always_comb begin
        w_fill_next = r_fill;
        if ((r_s1_col == 12'd0) || (r_s1_col != r_s2_col + 12'd1)) begin
            w_fill_next = 4'd1;
        end else if (r_fill != FILL_FULL) begin
            w_fill_next = r_fill + 4'd1;
        end
    end

    // Stage 2: shift the new column into the window history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_fill     <= '0;
            r_s2_row   <= '0;
            r_s2_col   <= '0;
            for (int k = 0; k < int'(WIN_COLS); k++) begin
                r_hist_cs[k]  <= '0;
                r_hist_pix[k] <= '0;
            end
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_hist_cs[0]  <= r_s1_cs;
                r_hist_pix[0] <= r_s1_cut;
                for (int k = 1; k < int'(WIN_COLS); k++) begin
                    r_hist_cs[k]  <= r_hist_cs[k-1];
                    r_hist_pix[k] <= r_hist_pix[k-1];
                end
                r_fill   <= w_fill_next;
                r_s2_row <= r_s1_row;
                r_s2_col <= r_s1_col;
            end
        end
    end

    assign w_s2_fire = r_s2_valid && (r_fill == FILL_FULL);
    assign w_cut     = r_hist_pix[CENTRE];

    // Reference sum skips the CUT and its guard columns.
    always_comb begin
        w_ref_sum = '0;
        for (int k = 0; k < int'(WIN_COLS); k++) begin
            if ((k < GUARD_LO) || (k > GUARD_HI)) begin
                w_ref_sum = w_ref_sum + {5'b00000, r_hist_cs[k]};
            end
        end
    end

    // Full-width products so the strict compare never loses precision.
    always_comb begin
        w_lhs  = {16'd0, w_cut} * CUT_SCALE;
        w_rhs  = {{(PROD_W-8){1'b0}}, ALPHA_Q} * {8'd0, w_ref_sum};
        w_flag = (w_lhs > w_rhs);
    end

    // Stage 3: publish a result; data outputs hold between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_valid <= 1'b0;
            det_flag  <= 1'b0;
            det_row   <= '0;
            det_col   <= '0;
            cut_value <= '0;
            ref_sum   <= '0;
        end else begin
            det_valid <= w_s2_fire;
            if (w_s2_fire) begin
                det_flag  <= w_flag;
                det_row   <= r_s2_row + 12'd2;
                det_col   <= r_s2_col - CENTRE_COL;
                cut_value <= w_cut;
                ref_sum   <= w_ref_sum;
            end
        end
    end

`ifdef CFAR_DET_COUNT_EN
    // Saturating count of flagged results; a row-0/col-0 beat starts a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_count <= '0;
        end else if (valid_in && (row_in == 12'd0) && (col_in == 12'd0)) begin
            det_count <= '0;
        end else if (w_s2_fire && w_flag && (det_count != 32'hFFFF_FFFF)) begin
            det_count <= det_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cfar_window_detector.sv
// Directed bench for cfar_window_detector: table-driven window scenarios plus
// hand-written reset and (when CFAR_DET_COUNT_EN is defined) counter sequences.
module tb_cfar_window_detector;

    localparam int DW  = 16;
    localparam int LOG = 2048;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic [11:0]       row_in;
    logic [11:0]       col_in;
    logic [10*DW-1:0]  pixel_in;
    logic              det_valid;
    logic              det_flag;
    logic [11:0]       det_row;
    logic [11:0]       det_col;
    logic [DW-1:0]     cut_value;
    logic [DW+7:0]     ref_sum;
`ifdef CFAR_DET_COUNT_EN
    logic [31:0]       det_count;
`endif

    cfar_window_detector #(
        .DATA_WIDTH (16),
        .WIN_COLS   (9),
        .GUARD      (1),
        .ALPHA_Q    (8'd48)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .row_in    (row_in),
        .col_in    (col_in),
        .pixel_in  (pixel_in),
        .det_valid (det_valid),
        .det_flag  (det_flag),
        .det_row   (det_row),
        .det_col   (det_col),
        .cut_value (cut_value),
        .ref_sum   (ref_sum)
`ifdef CFAR_DET_COUNT_EN
        ,
        .det_count (det_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] row;
        logic [11:0] col;
        logic [15:0] px;     // pixel(2,0); every other column-0 pixel is 100
        logic        ev;     // a result is expected 3 cycles after this beat
        logic [11:0] ecol;
        logic [11:0] erow;
        logic        eflag;
        logic [15:0] ecut;
        logic [23:0] eref;
    } vec_t;

    vec_t vt [64];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic        lg_valid [LOG];
    logic        lg_flag  [LOG];
    logic [11:0] lg_row   [LOG];
    logic [11:0] lg_col   [LOG];
    logic [15:0] lg_cut   [LOG];
    logic [23:0] lg_ref   [LOG];

    function automatic vec_t mk(input int row, input int col, input int px, input bit ev,
                                input int ecol, input int erow, input bit eflag,
                                input int ecut, input int eref);
        vec_t m;
        m.row   = 12'(row);
        m.col   = 12'(col);
        m.px    = 16'(px);
        m.ev    = ev;
        m.ecol  = 12'(ecol);
        m.erow  = 12'(erow);
        m.eflag = eflag;
        m.ecut  = 16'(ecut);
        m.eref  = 24'(eref);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [11:0] row, input logic [11:0] col,
                         input logic [15:0] px);
        valid_in = v;
        row_in   = row;
        col_in   = col;
        for (int i = 0; i < 5; i++) begin
            pixel_in[(2*i)*DW +: DW]   = (i == 2) ? px : 16'd100;
            pixel_in[(2*i+1)*DW +: DW] = 16'hFFFF;   // column 1 must be ignored
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the edge into lg[cyc].
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < LOG) begin
            lg_valid[cyc] = det_valid;
            lg_flag[cyc]  = det_flag;
            lg_row[cyc]   = det_row;
            lg_col[cyc]   = det_col;
            lg_cut[cyc]   = cut_value;
            lg_ref[cyc]   = ref_sum;
        end
    endtask

    task automatic beat(input int row, input int col, input int px);
        drive(1'b1, 12'(row), 12'(col), 16'(px));
        tick();
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) tick();
    endtask

    // Apply table rows [first, first+n) with `gap` idle cycles after each beat.
    task automatic run_range(input string tag, input int first, input int n, input int gap);
        int bcyc [64];
        int start;
        int nexp;
        int ngot;
        logic [11:0] last_col;
        start    = cyc;
        nexp     = 0;
        ngot     = 0;
        last_col = '0;
        for (int i = 0; i < n; i++) begin
            bcyc[i] = cyc;   // beat occupies this cycle; result lands in bcyc+3
            beat(int'(vt[first+i].row), int'(vt[first+i].col), int'(vt[first+i].px));
            idle(gap);
        end
        idle(5);
        for (int c = start + 1; c <= cyc; c++) begin
            if (lg_valid[c] === 1'b1) ngot++;
        end
        for (int i = 0; i < n; i++) begin
            vec_t v;
            int   t;
            v = vt[first+i];
            if (v.ev) begin
                nexp++;
                last_col = v.ecol;
                t = bcyc[i] + 3;
                chk($sformatf("%s v%0d det_valid", tag, i), 32'(lg_valid[t]), 32'd1);
                chk($sformatf("%s v%0d det_flag", tag, i), 32'(lg_flag[t]), 32'(v.eflag));
                chk($sformatf("%s v%0d det_row", tag, i), 32'(lg_row[t]), 32'(v.erow));
                chk($sformatf("%s v%0d det_col", tag, i), 32'(lg_col[t]), 32'(v.ecol));
                chk($sformatf("%s v%0d cut_value", tag, i), 32'(lg_cut[t]), 32'(v.ecut));
                chk($sformatf("%s v%0d ref_sum", tag, i), 32'(lg_ref[t]), 32'(v.eref));
            end
        end
        chk($sformatf("%s result count", tag), 32'(ngot), 32'(nexp));
        chk($sformatf("%s idle det_valid", tag), 32'(det_valid), 32'd0);
        chk($sformatf("%s held det_col", tag), 32'(det_col), 32'(last_col));
    endtask

    initial begin
        int idx;
        int d;
        int rb;
        int b18;
        int ncnt;

        // Flat field, row 0, cols 0..20: results from col 8 on, det_col = col-4.
        idx = 0;
        for (int c = 0; c <= 20; c++) begin
            vt[idx] = mk(0, c, 100, c >= 8, c - 4, 2, 1'b0, 100, 3000);
            idx++;
        end
        // Spike of 1000 at col 10: column sum 1400 raises ref_sum to 3900 whenever
        // col 10 sits in the reference cells (|det_col-10| in 2..4).
        for (int c = 0; c <= 20; c++) begin
            d = c - 4;
            vt[idx] = mk(0, c, (c == 10) ? 1000 : 100, c >= 8, d, 2, d == 10,
                         (d == 10) ? 1000 : 100,
                         ((d - 10 >= 2 && d - 10 <= 4) || (10 - d >= 2 && 10 - d <= 4))
                             ? 3900 : 3000);
            idx++;
        end
        // Column jump 7 -> 12 on row 5: only the col 20 beat completes a window.
        for (int c = 0; c <= 20; c++) begin
            if (c < 8 || c >= 12) begin
                vt[idx] = mk(5, c, 100, c == 20, 16, 7, 1'b0, 100, 3000);
                idx++;
            end
        end

        // Reset state
        rst = 1'b1;
        drive(1'b1, 12'd3, 12'd4, 16'd500);
        tick();
        tick();
        chk("reset det_valid", 32'(det_valid), 32'd0);
        chk("reset det_flag", 32'(det_flag), 32'd0);
        chk("reset det_row", 32'(det_row), 32'd0);
        chk("reset det_col", 32'(det_col), 32'd0);
        chk("reset cut_value", 32'(cut_value), 32'd0);
        chk("reset ref_sum", 32'(ref_sum), 32'd0);
        rst = 1'b0;
        idle(2);

        run_range("flat", 0, 21, 0);
        run_range("spike", 21, 21, 0);
        run_range("bubble", 21, 21, 2);
        run_range("jump", 42, 17, 0);

        // Reset mid-row at col 9: in-flight col 8 result is discarded.
        for (int c = 0; c <= 8; c++) beat(0, c, 100);
        rst = 1'b1;
        drive(1'b1, 12'd0, 12'd9, 16'd100);
        tick();
        rst = 1'b0;
        valid_in = 1'b0;
        rb = cyc;
        chk("midrst det_valid", 32'(det_valid), 32'd0);
        chk("midrst det_flag", 32'(det_flag), 32'd0);
        chk("midrst det_row", 32'(det_row), 32'd0);
        chk("midrst det_col", 32'(det_col), 32'd0);
        chk("midrst cut_value", 32'(cut_value), 32'd0);
        chk("midrst ref_sum", 32'(ref_sum), 32'd0);
        for (int c = 10; c <= 17; c++) beat(0, c, 100);
        b18 = cyc;
        beat(0, 18, 100);
        idle(4);
        ncnt = 0;
        for (int c = rb + 1; c <= b18 + 2; c++) begin
            if (lg_valid[c] === 1'b1) ncnt++;
        end
        chk("midrst quiet beats", 32'(ncnt), 32'd0);
        chk("midrst first det_valid", 32'(lg_valid[b18+3]), 32'd1);
        chk("midrst first det_col", 32'(lg_col[b18+3]), 32'd14);
        chk("midrst first ref_sum", 32'(lg_ref[b18+3]), 32'd3000);

`ifdef CFAR_DET_COUNT_EN
        // One spike per row on rows 1..3, each detected at det_col 4.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("count reset", det_count, 32'd0);
        for (int r = 1; r <= 3; r++) begin
            for (int c = 0; c <= 8; c++) beat(r, c, (c == 4) ? 1000 : 100);
        end
        idle(4);
        chk("count three spikes", det_count, 32'd3);
        beat(0, 0, 100);
        chk("count frame clear", det_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
